// File: rtl/uart_cmd_ctrl.sv
// UART command frame parser: SYNC(0xA5), ADDR, DATA, CHK -> write into an 8x8-bit register bank.
// Rejected frames (checksum, bad address, inter-byte timeout) raise a one-cycle error pulse.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    output logic [63:0] o_regs,
    output logic        o_wr_strobe,
    output logic [2:0]  o_wr_addr,
    output logic        o_err_pulse,
    output logic [1:0]  o_err_code
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SyncByte   = 8'hA5;
    localparam logic [1:0] ErrChksum  = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrBadAddr = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StGetChk
    } state_e;

    state_e          state_q, state_d;
    logic            prev_valid_q;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     regs_q, regs_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [2:0]      wr_addr_q, wr_addr_d;
    logic            err_pulse_q, err_pulse_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            accept;
    logic            timeout;
    logic [7:0]      chk_sum;

    // Rising edge of valid only, so a byte held for many cycles is taken once.
    assign accept  = i_rx_valid & ~prev_valid_q;
    assign timeout = (cnt_q == CntLast) && !accept;
    assign chk_sum = SyncByte + addr_q + data_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept && (i_rx_byte == SyncByte)) begin
                    state_d = StGetAddr;
                end
            end
            StGetAddr, StGetData, StGetChk: begin
                if (accept) begin
                    cnt_d = '0;
                    unique case (state_q)
                        StGetAddr: begin
                            addr_d  = i_rx_byte;
                            state_d = StGetData;
                        end
                        StGetData: begin
                            data_d  = i_rx_byte;
                            state_d = StGetChk;
                        end
                        default: begin
                            state_d = StIdle;
                            if (i_rx_byte != chk_sum) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ErrChksum;
                            end else if (addr_q[7:3] != 5'd0) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ErrBadAddr;
                            end else begin
                                regs_d[{addr_q[2:0], 3'b000} +: 8] = data_q;
                                wr_addr_d   = addr_q[2:0];
                                wr_strobe_d = 1'b1;
                            end
                        end
                    endcase
                end else if (timeout) begin
                    cnt_d       = '0;
                    state_d     = StIdle;
                    err_pulse_d = 1'b1;
                    err_code_d  = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            prev_valid_q <= 1'b1;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            regs_q       <= '0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= i_rx_valid;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            regs_q       <= regs_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    assign o_regs      = regs_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_err_pulse = err_pulse_q;
    assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: one default-timeout instance and one with TIMEOUT_CYCLES=20,
// both fed the same byte stream.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;

    logic [63:0] regs, regs_t;
    logic        strobe, strobe_t;
    logic [2:0]  waddr, waddr_t;
    logic        errp, errp_t;
    logic [1:0]  code, code_t;

    int n_cmp = 0;
    int n_err = 0;

    int strobe_cnt = 0, err_cnt = 0, both_cnt = 0;
    int strobe_cnt_t = 0, err_cnt_t = 0;
    int base_s, base_e;

    logic [63:0] snap_regs;
    logic        snap_strobe, snap_err;
    logic [2:0]  snap_addr;
    logic [1:0]  snap_code;

    uart_cmd_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .o_regs      (regs),
        .o_wr_strobe (strobe),
        .o_wr_addr   (waddr),
        .o_err_pulse (errp),
        .o_err_code  (code)
    );

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(20)) u_dut_t (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .o_regs      (regs_t),
        .o_wr_strobe (strobe_t),
        .o_wr_addr   (waddr_t),
        .o_err_pulse (errp_t),
        .o_err_code  (code_t)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge; a two-cycle pulse counts twice.
    always @(negedge clk) begin
        if (rst_n) begin
            strobe_cnt   += int'(strobe);
            err_cnt      += int'(errp);
            both_cnt     += int'(strobe & errp) + int'(strobe_t & errp_t);
            strobe_cnt_t += int'(strobe_t);
            err_cnt_t    += int'(errp_t);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Valid rises at a negedge, is accepted at the next posedge, outputs are snapshotted at the
    // following negedge, valid stays high for 'hold' cycles in total.
    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        snap_regs   = regs;
        snap_strobe = strobe;
        snap_err    = errp;
        snap_addr   = waddr;
        snap_code   = code;
        repeat (hold - 1) @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5, 1);
        send(a, 1);
        send(d, 1);
        send(c, 1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_regs", regs, 64'h0);
        check("rst_addr", 64'(waddr), 64'h0);
        check("rst_code", 64'(code), 64'h0);
        check("rst_strobe", 64'(strobe), 64'h0);
        check("rst_errp", 64'(errp), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame to reg 3
        send_frame(8'h03, 8'h5C, 8'h04);
        check("good_reg3", 64'(snap_regs[31:24]), 64'h5C);
        check("good_regs", snap_regs, 64'h0000_0000_5C00_0000);
        check("good_addr", 64'(snap_addr), 64'h3);
        check("good_strobe", 64'(snap_strobe), 64'h1);
        check("good_code", 64'(snap_code), 64'h0);
        repeat (3) @(negedge clk);
        check("good_strobe_cnt", 64'(strobe_cnt), 64'd1);
        check("good_err_cnt", 64'(err_cnt), 64'd0);

        // Checksum error
        send_frame(8'h03, 8'h5C, 8'h05);
        check("chk_errp", 64'(snap_err), 64'h1);
        check("chk_code", 64'(snap_code), 64'h1);
        check("chk_nostrobe", 64'(snap_strobe), 64'h0);
        repeat (3) @(negedge clk);
        check("chk_regs", regs, 64'h0000_0000_5C00_0000);
        check("chk_err_cnt", 64'(err_cnt), 64'd1);

        // Bad address
        send_frame(8'h09, 8'h11, 8'hBF);
        check("badaddr_code", 64'(snap_code), 64'h3);
        repeat (3) @(negedge clk);
        check("badaddr_regs", regs, 64'h0000_0000_5C00_0000);
        check("badaddr_strobe_cnt", 64'(strobe_cnt), 64'd1);
        check("badaddr_err_cnt", 64'(err_cnt), 64'd2);

        // Long valid pulses with leading junk
        send(8'h00, 50);
        send(8'hFF, 50);
        send(8'hA5, 50);
        send(8'h07, 50);
        send(8'h01, 50);
        send(8'hAD, 50);
        repeat (3) @(negedge clk);
        check("long_regs", regs, 64'h0100_0000_5C00_0000);
        check("long_addr", 64'(waddr), 64'h7);
        check("long_strobe_cnt", 64'(strobe_cnt), 64'd2);
        check("long_err_cnt", 64'(err_cnt), 64'd2);
        check("long_code_held", 64'(code), 64'h3);

        // Reset mid-frame
        send(8'hA5, 1);
        send(8'h04, 1);
        send(8'h33, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_regs", regs, 64'h0);
        check("midrst_code", 64'(code), 64'h0);
        check("midrst_addr", 64'(waddr), 64'h0);
        check("midrst_strobe", 64'(strobe), 64'h0);
        check("midrst_errp", 64'(errp), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        base_s = strobe_cnt;
        send(8'hDC, 1);
        repeat (3) @(negedge clk);
        check("midrst_nocommit", regs, 64'h0);
        check("midrst_strobe_cnt", 64'(strobe_cnt - base_s), 64'd0);
        check("midrst_code_after", 64'(code), 64'h0);

        // Valid already high at reset release must not be accepted
        @(negedge clk);
        rx_byte  = 8'hA5;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        send(8'h03, 1);
        send(8'h5C, 1);
        send(8'h04, 1);
        repeat (3) @(negedge clk);
        check("relhigh_regs", regs, 64'h0);
        check("relhigh_strobe_cnt", 64'(strobe_cnt - base_s), 64'd0);

        // Timeout on the 20-cycle instance: terminal count 19 cycles after the ADDR accept
        base_e = err_cnt_t;
        base_s = strobe_cnt_t;
        send(8'hA5, 1);
        send(8'h02, 1);
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("to_not_early", 64'(errp_t), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("to_errp", 64'(errp_t), 64'h1);
        check("to_code", 64'(code_t), 64'h2);
        @(negedge clk);
        check("to_errp_width", 64'(errp_t), 64'h0);
        repeat (9) @(negedge clk);
        check("to_err_cnt", 64'(err_cnt_t - base_e), 64'd1);
        send_frame(8'h02, 8'h77, 8'h1E);
        repeat (2) @(negedge clk);
        check("to_recover_regs", regs_t, 64'h0000_0000_0077_0000);
        check("to_recover_strobe", 64'(strobe_cnt_t - base_s), 64'd1);
        check("to_recover_addr", 64'(waddr_t), 64'h2);

        // Accept landing exactly on the terminal-count cycle wins over the timeout
        base_e = err_cnt_t;
        send(8'hA5, 1);
        repeat (18) @(posedge clk);
        send(8'h05, 1);
        send(8'h10, 1);
        send(8'hBA, 1);
        repeat (3) @(negedge clk);
        check("tc_regs", regs_t, 64'h0000_1000_0077_0000);
        check("tc_no_err", 64'(err_cnt_t - base_e), 64'd0);
        check("tc_code_held", 64'(code_t), 64'h2);

        check("never_both", 64'(both_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 50000, the inter-byte timeout in i_clk cycles (min 2).
REQ-002 SHALL provide port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port i_rx_valid  input  1  byte-valid from the UART receiver; may stay high for many cycles per byte.
REQ-005 SHALL provide port i_rx_byte  input  8  received byte; stable while i_rx_valid is high.
REQ-006 SHALL provide port o_regs  output  64  register bank; reg k occupies bits [8k+7:8k], k=0..7.
REQ-007 SHALL provide port o_wr_strobe  output  1  one-cycle pulse marking a committed register write.
REQ-008 SHALL provide port o_wr_addr  output  3  index of the last committed write.
REQ-009 SHALL provide port o_err_pulse  output  1  one-cycle pulse marking a rejected frame.
REQ-010 SHALL provide port o_err_code  output  2  last error: 00 none, 01 checksum, 10 timeout, 11 bad address.

Function
REQ-011 SHALL accept a byte only in a cycle where i_rx_valid=1 and its value in the previous cycle was 0; at most one accept per high pulse.
REQ-012 SHALL parse 4-byte frames: SYNC=0xA5, ADDR, DATA, CHK, where CHK = (0xA5 + ADDR + DATA) mod 256.
REQ-013 SHALL implement states IDLE, GET_ADDR, GET_DATA, GET_CHK; any unused encoding returns to IDLE next cycle.
REQ-014 IDLE: accepted 0xA5 -> GET_ADDR; any other accepted byte is discarded silently; no error.
REQ-015 GET_ADDR: accept latches ADDR -> GET_DATA; GET_DATA: accept latches DATA -> GET_CHK; 0xA5 has no special meaning here.
REQ-016 GET_CHK: on accept -> IDLE, then exactly one of: checksum mismatch -> error 01; checksum ok and ADDR[7:3]!=0 -> error 11; else commit write.
REQ-017 Commit SHALL, one cycle after the accepting cycle, update reg ADDR[2:0] to DATA, set o_wr_addr=ADDR[2:0], and assert o_wr_strobe for exactly one cycle.
REQ-018 Error SHALL, one cycle after the detecting cycle, set o_err_code and assert o_err_pulse for exactly one cycle; o_err_code holds until the next error or reset; a commit does not clear it.
REQ-019 A timeout counter SHALL clear on every accept and on entry to IDLE, and increment each cycle in GET_ADDR/GET_DATA/GET_CHK without an accept.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1 without an accept SHALL go to IDLE with error 10; the counter is inactive in IDLE.
REQ-021 If an accept coincides with the timeout terminal count, the accept SHALL win and no timeout is raised.
REQ-022 o_wr_strobe and o_err_pulse SHALL never be high in the same cycle; a failed frame leaves o_regs unchanged.
REQ-023 Back-to-back frames SHALL be accepted with no gap cycles required beyond the valid low-to-high edge.

Reset
REQ-024 Asserting i_rst_n=0 SHALL immediately force state IDLE, counter 0, o_regs all 0x00, o_wr_addr 0, o_err_code 00, o_wr_strobe 0, o_err_pulse 0, including mid-frame.
REQ-025 The previous-valid history SHALL reset to 1, so i_rx_valid already high at reset release is not accepted.
REQ-026 A partially received frame SHALL be discarded by reset and never committed.

Verification
REQ-027 Bytes A5,03,5C,04 -> one cycle later o_regs[31:24]=0x5C, o_wr_addr=3, o_wr_strobe high 1 cycle, o_err_code=00.
REQ-028 Bytes A5,03,5C,05 -> o_err_pulse 1 cycle, o_err_code=01, o_regs unchanged.
REQ-029 Bytes A5,09,11,BF -> o_err_code=11, no strobe, o_regs unchanged.
REQ-030 TIMEOUT_CYCLES=20; A5,02 then idle 30 cycles -> error 10 exactly 19 idle cycles after ADDR accept; next A5,02,77,1E commits reg 2=0x77.
REQ-031 Bytes 00,FF,A5,07,01,AD with i_rx_valid held high 50 cycles each -> only reg 7=0x01 written, single strobe.
REQ-032 i_rst_n low after A5,04,33 then frame completed post-reset -> no commit, all outputs at reset values.
